// File: rtl/router_nport_if.sv
// router_nport_if: bundles the per-port serial input and output lines of the router.
// Drivers of packets use the master modport and the router uses the slave modport.
interface router_nport_if #(
    parameter int NPORT = 16
);
    logic [NPORT-1:0] din;
    logic [NPORT-1:0] frame_n;
    logic [NPORT-1:0] valid_n;
    logic [NPORT-1:0] busy_n;
    logic [NPORT-1:0] dout;
    logic [NPORT-1:0] valido_n;
    logic [NPORT-1:0] frameo_n;

    modport master (
        output din,
        output frame_n,
        output valid_n,
        input  busy_n,
        input  dout,
        input  valido_n,
        input  frameo_n
    );

    modport slave (
        input  din,
        input  frame_n,
        input  valid_n,
        output busy_n,
        output dout,
        output valido_n,
        output frameo_n
    );
endinterface

// File: rtl/router_nport.sv
// router_nport: NPORT-input, NPORT-output serial packet router.
// Each input collects an LSB-first destination address, then waits for a
// round-robin grant on that output and streams its bits through with one
// cycle of latency. Illegal addresses are swallowed until the frame ends.
module router_nport #(
    parameter int NPORT  = 16,
    parameter int ADDR_W = $clog2(NPORT)
) (
    input  logic          clk,
    input  logic          reset_n,
    router_nport_if.slave bus
);
    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ARB,
        ST_PASS,
        ST_DROP
    } state_t;

    // Per-input packet state
    state_t            r_state      [NPORT];
    state_t            w_stateNext  [NPORT];
    logic [ADDR_W-1:0] r_addr       [NPORT];
    logic [ADDR_W-1:0] w_addrShift  [NPORT];
    logic [7:0]        r_cnt        [NPORT];
    logic [NPORT-1:0]  w_addrDone;
    logic [NPORT-1:0]  w_addrLegal;
    logic [NPORT-1:0]  w_addrLoad;
    logic [NPORT-1:0]  r_armed;
    logic [NPORT-1:0]  r_busy_n;
    logic [NPORT-1:0]  w_busyNext_n;
    logic [NPORT-1:0]  w_granted;

    // Per-output ownership and arbitration
    logic [NPORT-1:0]  r_ownerValid;
    logic [IDX_W-1:0]  r_owner      [NPORT];
    logic [IDX_W-1:0]  r_ptr        [NPORT];
    logic [NPORT-1:0]  w_grantValid;
    logic [IDX_W-1:0]  w_grantIdx   [NPORT];
    logic [NPORT-1:0]  w_release;

    // Registered output lines
    logic [NPORT-1:0]  r_dout;
    logic [NPORT-1:0]  r_valido_n;
    logic [NPORT-1:0]  r_frameo_n;

    // Round-robin candidate: the input k places after the priority pointer.
    function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] ptr, input int k);
        return IDX_W'((int'(ptr) + k) % NPORT);
    endfunction

    // Address assembly: new bits enter at the MSB so the first bit ends up in bit 0.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            if (r_state[i] == ST_IDLE) begin
                w_addrShift[i] = ADDR_W'(bus.din[i]) << (ADDR_W - 1);
                w_addrDone[i]  = (ADDR_W == 1);
                w_addrLoad[i]  = !bus.frame_n[i] && r_armed[i];
            end else begin
                w_addrShift[i] = (r_addr[i] >> 1) | (ADDR_W'(bus.din[i]) << (ADDR_W - 1));
                w_addrDone[i]  = (int'(r_cnt[i]) == ADDR_W - 1);
                w_addrLoad[i]  = (r_state[i] == ST_ADDR) && !bus.frame_n[i];
            end
            w_addrLegal[i] = int'(w_addrShift[i]) < NPORT;
        end
    end

    // Per-output round-robin arbiter; a busy output grants nobody this cycle.
    always_comb begin
        w_granted = '0;
        for (int d = 0; d < NPORT; d++) begin
            w_grantValid[d] = 1'b0;
            w_grantIdx[d]   = '0;
            if (!r_ownerValid[d]) begin
                for (int k = 0; k < NPORT; k++) begin
                    if (!w_grantValid[d] &&
                        r_state[rrIndex(r_ptr[d], k)] == ST_ARB &&
                        int'(r_addr[rrIndex(r_ptr[d], k)]) == d) begin
                        w_grantValid[d] = 1'b1;
                        w_grantIdx[d]   = rrIndex(r_ptr[d], k);
                        w_granted[rrIndex(r_ptr[d], k)] = 1'b1;
                    end
                end
            end
        end
    end

    // An owned output is freed on the edge where its owner samples frame_n high.
    always_comb begin
        for (int d = 0; d < NPORT; d++) begin
            w_release[d] = r_ownerValid[d] && bus.frame_n[r_owner[d]];
        end
    end

    // Input FSM next-state decode.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_stateNext[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_addrLoad[i]) begin
                        if (w_addrDone[i]) begin
                            w_stateNext[i] = w_addrLegal[i] ? ST_ARB : ST_DROP;
                        end else begin
                            w_stateNext[i] = ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.frame_n[i]) begin
                        w_stateNext[i] = ST_IDLE;
                    end else if (w_addrDone[i]) begin
                        w_stateNext[i] = w_addrLegal[i] ? ST_ARB : ST_DROP;
                    end
                end
                ST_ARB: begin
                    if (w_granted[i]) begin
                        w_stateNext[i] = ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (bus.frame_n[i]) begin
                        w_stateNext[i] = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (bus.frame_n[i]) begin
                        w_stateNext[i] = ST_IDLE;
                    end
                end
                default: w_stateNext[i] = ST_IDLE;
            endcase
        end
    end

    // Input FSM output decode: busy_n is low exactly while waiting in ARB.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_busyNext_n[i] = (w_stateNext[i] != ST_ARB);
        end
    end

    // Input FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPORT; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                r_state[i] <= w_stateNext[i];
            end
        end
    end

    // Per-input datapath: address shifter, bit counter, re-arm flag and busy_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed  <= '0;
            r_busy_n <= '1;
            for (int i = 0; i < NPORT; i++) begin
                r_addr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_armed  <= r_armed | bus.frame_n;
            r_busy_n <= w_busyNext_n;
            for (int i = 0; i < NPORT; i++) begin
                if (w_addrLoad[i]) begin
                    r_addr[i] <= w_addrShift[i];
                    r_cnt[i]  <= (r_state[i] == ST_IDLE) ? 8'd1 : r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Output ownership and round-robin pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ownerValid <= '0;
            for (int d = 0; d < NPORT; d++) begin
                r_owner[d] <= '0;
                r_ptr[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < NPORT; d++) begin
                if (w_grantValid[d]) begin
                    r_ownerValid[d] <= 1'b1;
                    r_owner[d]      <= w_grantIdx[d];
                    r_ptr[d]        <= rrIndex(w_grantIdx[d], 1);
                end else if (w_release[d]) begin
                    r_ownerValid[d] <= 1'b0;
                end
            end
        end
    end

    // Output registers: mirror the owning input one cycle later, else idle values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout     <= '0;
            r_valido_n <= '1;
            r_frameo_n <= '1;
        end else begin
            for (int d = 0; d < NPORT; d++) begin
                if (r_ownerValid[d]) begin
                    r_dout[d]     <= !bus.valid_n[r_owner[d]] && bus.din[r_owner[d]];
                    r_valido_n[d] <= bus.valid_n[r_owner[d]];
                    r_frameo_n[d] <= bus.frame_n[r_owner[d]];
                end else begin
                    r_dout[d]     <= 1'b0;
                    r_valido_n[d] <= 1'b1;
                    r_frameo_n[d] <= 1'b1;
                end
            end
        end
    end

    assign bus.busy_n   = r_busy_n;
    assign bus.dout     = r_dout;
    assign bus.valido_n = r_valido_n;
    assign bus.frameo_n = r_frameo_n;

endmodule

// File: tb/tb_router_nport.sv
// tb_router_nport: scoreboard bench for router_nport with a 16-port and a 12-port instance.
module tb_router_nport;
    localparam int N16 = 16;
    localparam int N12 = 12;

    typedef struct {
        logic d;
        logic f;
        int   c;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   monOff = 1'b0;

    logic [N16-1:0] din16, frame16, valid16;
    logic [N12-1:0] din12, frame12, valid12;

    exp_t q16 [N16][$];
    exp_t q12 [N12][$];

    router_nport_if #(.NPORT(N16)) bus16 ();
    router_nport_if #(.NPORT(N12)) bus12 ();

    assign bus16.din     = din16;
    assign bus16.frame_n = frame16;
    assign bus16.valid_n = valid16;
    assign bus12.din     = din12;
    assign bus12.frame_n = frame12;
    assign bus12.valid_n = valid12;

    router_nport #(.NPORT(N16)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    router_nport #(.NPORT(N12)) dut12 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus12)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic driveBit(input int inst, input int port, input logic d, input logic f, input logic v);
        if (inst == 0) begin
            din16[port] = d; frame16[port] = f; valid16[port] = v;
        end else begin
            din12[port] = d; frame12[port] = f; valid12[port] = v;
        end
    endtask

    function automatic logic getBusy(input int inst, input int port);
        return (inst == 0) ? bus16.busy_n[port] : bus12.busy_n[port];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one packet: address LSB first, hold data while busy, then stream the data bits.
    task automatic applyStimulus(input int inst, input int port, input int addr, input int nAddr,
                                 input logic [7:0] data, input int nData, input bit expectOut,
                                 output int busyCycles);
        int   budget;
        int   sent;
        logic last;
        exp_t e;
        busyCycles = 0;
        for (int b = 0; b < nAddr; b++) begin
            @(negedge clk);
            driveBit(inst, port, logic'((addr >> b) & 1), 1'b0, 1'b1);
        end
        if (nData > 0) begin
            budget = 40;
            sent   = 0;
            while (sent < nData) begin
                @(negedge clk);
                if (getBusy(inst, port) == 1'b0) begin
                    busyCycles++;
                    driveBit(inst, port, 1'b1, 1'b0, 1'b0);
                    budget--;
                    if (budget == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL grant_timeout inst=%0d port=%0d: busy_n still 0, expected 1", inst, port);
                        break;
                    end
                end else begin
                    last = (sent == nData - 1);
                    driveBit(inst, port, data[sent], last, 1'b0);
                    if (expectOut) begin
                        e.d = data[sent];
                        e.f = last;
                        e.c = cyc + 1;
                        if (inst == 0) q16[addr].push_back(e);
                        else           q12[addr].push_back(e);
                    end
                    sent++;
                end
            end
        end
        @(negedge clk);
        driveBit(inst, port, 1'b0, 1'b1, 1'b1);
    endtask

    // Scoreboard comparison for one output port in the current cycle.
    task automatic scoreOutput(input int inst, input int d, input logic dv, input logic vv, input logic fv);
        exp_t e;
        bit   empty;
        if (vv === 1'b1) begin
            checks++;
            if (dv !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_dout inst=%0d port=%0d: got %b, expected 0", inst, d, dv);
            end
        end else if (!(monOff && inst == 0)) begin
            checks++;
            empty = (inst == 0) ? (q16[d].size() == 0) : (q12[d].size() == 0);
            if (empty) begin
                errors++;
                $display("[TB] FAIL unexpected_out inst=%0d port=%0d cyc=%0d: got valido_n=%b, expected 1", inst, d, cyc, vv);
            end else begin
                if (inst == 0) e = q16[d].pop_front();
                else           e = q12[d].pop_front();
                if (dv !== e.d || fv !== e.f || cyc != e.c) begin
                    errors++;
                    $display("[TB] FAIL out_bit inst=%0d port=%0d: got d=%b f=%b cyc=%0d, expected d=%b f=%b cyc=%0d",
                             inst, d, dv, fv, cyc, e.d, e.f, e.c);
                end
            end
        end
    endtask

    // Monitor: inspect every output port once per cycle, away from the rising edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int d = 0; d < N16; d++) scoreOutput(0, d, bus16.dout[d], bus16.valido_n[d], bus16.frameo_n[d]);
            for (int d = 0; d < N12; d++) scoreOutput(1, d, bus12.dout[d], bus12.valido_n[d], bus12.frameo_n[d]);
        end
    end

    initial begin
        int bcA, bcB, pend;
        din16 = '0; frame16 = '1; valid16 = '1;
        din12 = '0; frame12 = '1; valid12 = '1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy16",   int'(bus16.busy_n),   32'hFFFF);
        checkOutput("rst_dout16",   int'(bus16.dout),     0);
        checkOutput("rst_valido16", int'(bus16.valido_n), 32'hFFFF);
        checkOutput("rst_frameo16", int'(bus16.frameo_n), 32'hFFFF);
        checkOutput("rst_busy12",   int'(bus12.busy_n),   32'hFFF);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single packet 3 -> 5 carrying 0xA5
        applyStimulus(0, 3, 5, 4, 8'hA5, 8, 1, bcA);
        checkOutput("single_busy", bcA, 1);
        repeat (2) @(negedge clk);

        // Inputs 0 and 7 contend for output 2 with the pointer at 0
        fork
            applyStimulus(0, 0, 2, 4, 8'hC3, 8, 1, bcA);
            applyStimulus(0, 7, 2, 4, 8'h5E, 8, 1, bcB);
        join
        checkOutput("rr0_busy_in0", bcA, 1);
        checkOutput("rr0_busy_in7", bcB, 10);
        repeat (2) @(negedge clk);

        // Pointer now past input 7: input 9 beats input 3
        fork
            applyStimulus(0, 3, 2, 4, 8'h81, 8, 1, bcA);
            applyStimulus(0, 9, 2, 4, 8'h7E, 8, 1, bcB);
        join
        checkOutput("rr8_busy_in3", bcA, 10);
        checkOutput("rr8_busy_in9", bcB, 1);
        repeat (2) @(negedge clk);

        // Independent outputs granted on the same edge
        fork
            applyStimulus(0, 1, 9,  4, 8'h3C, 8, 1, bcA);
            applyStimulus(0, 2, 10, 4, 8'hE7, 8, 1, bcB);
        join
        checkOutput("par_busy_in1", bcA, 1);
        checkOutput("par_busy_in2", bcB, 1);
        repeat (2) @(negedge clk);

        // Abort after two address bits, then a normal packet from the same input
        applyStimulus(0, 5, 8, 2, 8'h00, 0, 0, bcA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("abort_busy", int'(bus16.busy_n[5]), 1);
        end
        applyStimulus(0, 5, 8, 4, 8'h99, 8, 1, bcA);
        checkOutput("after_abort_busy", bcA, 1);
        repeat (2) @(negedge clk);

        // 12-port instance: address 13 dropped, then address 4 routed
        applyStimulus(1, 2, 13, 4, 8'h3C, 8, 0, bcA);
        checkOutput("drop_busy", bcA, 0);
        applyStimulus(1, 2, 4, 4, 8'h96, 8, 1, bcA);
        checkOutput("after_drop_busy", bcA, 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a packet 4 -> 6
        monOff = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            driveBit(0, 4, logic'((6 >> b) & 1), 1'b0, 1'b1);
        end
        @(negedge clk);
        driveBit(0, 4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_pre_grant", int'(bus16.busy_n[4]), 1);
        driveBit(0, 4, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            driveBit(0, 4, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("rst_pass_active", int'(bus16.valido_n[6]), 0);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy16",   int'(bus16.busy_n),   32'hFFFF);
        checkOutput("midrst_dout16",   int'(bus16.dout),     0);
        checkOutput("midrst_valido16", int'(bus16.valido_n), 32'hFFFF);
        checkOutput("midrst_frameo16", int'(bus16.frameo_n), 32'hFFFF);
        driveBit(0, 4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        monOff  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("post_rst_ignore", int'(bus16.busy_n[4]), 1);
        end
        driveBit(0, 4, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 4, 6, 4, 8'h5A, 8, 1, bcA);
        checkOutput("post_rst_busy", bcA, 1);

        repeat (4) @(negedge clk);
        pend = 0;
        for (int d = 0; d < N16; d++) pend += q16[d].size();
        for (int d = 0; d < N12; d++) pend += q12[d].size();
        checkOutput("queues_drained", pend, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
